// File: rtl/principal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : principal_pkg
//  Description : Shared encodings for the arbitro_rr arbiter: operating modes,
//                FSM states and the 7-segment patterns shown for each grant.
//                Segment vectors are ordered {a,b,c,d,e,f,g}, active-high.
//  Revision    : 1.0 - initial release
// ============================================================================
package principal_pkg;

    // Mode select as presented on {e1,e0}
    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_RR    = 2'b01,
        MODE_LOCK  = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [6:0] SEG_IDX0 = 7'b1111110; // a b c d e f
    localparam logic [6:0] SEG_IDX1 = 7'b0110000; // b c
    localparam logic [6:0] SEG_IDX2 = 7'b1101101; // a b d e g
    localparam logic [6:0] SEG_IDX3 = 7'b1111001; // a b c d g
    localparam logic [6:0] SEG_DASH = 7'b0000001; // g only

endpackage : principal_pkg
`default_nettype wire

// File: rtl/decod_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : decod_7seg
//  Description : Maps a 2-bit requester index to an active-high 7-segment
//                glyph; the blank input overrides with a dash.
//  Ports       : idx[1:0] - index to show
//                blank    - show "-" instead of the index
//                seg_a..seg_g - segment drives
//  Revision    : 1.0 - initial release
// ============================================================================
module decod_7seg
    import principal_pkg::*;
(
    input  logic [1:0] idx,
    input  logic       blank,
    output logic       seg_a,
    output logic       seg_b,
    output logic       seg_c,
    output logic       seg_d,
    output logic       seg_e,
    output logic       seg_f,
    output logic       seg_g
);

    logic [6:0] w_seg;

    always_comb begin
        w_seg = SEG_DASH;
        if (!blank) begin
            case (idx)
                2'd0:    w_seg = SEG_IDX0;
                2'd1:    w_seg = SEG_IDX1;
                2'd2:    w_seg = SEG_IDX2;
                default: w_seg = SEG_IDX3;
            endcase
        end
    end

    assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = w_seg;

endmodule : decod_7seg
`default_nettype wire

// File: rtl/arbitro_rr.sv
`default_nettype none
// ============================================================================
//  Module      : arbitro_rr
//  Description : Four-way arbiter with fixed-priority, round-robin, lock and
//                disabled modes. A grant is held for at least MIN_HOLD cycles;
//                in round-robin mode a busy owner is preempted after MAX_HOLD
//                cycles when someone else is waiting. Every release passes
//                through one IDLE cycle.
//  Ports       : clk, rst (sync, active-high)
//                e1,e0     - mode {e1,e0}
//                p3..p0    - requests
//                g3..g0    - registered one-hot grant
//                y1,y0     - registered index of current/last grant
//                busy      - registered, high while a grant is active
//                seg_a..g  - 7-segment view of busy/y
//  Parameters  : MIN_HOLD 1..7, MAX_HOLD MIN_HOLD+1..15
//  Revision    : 1.0 - initial release
// ============================================================================
module arbitro_rr
    import principal_pkg::*;
#(
    parameter int MIN_HOLD = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic e1,
    input  logic e0,
    input  logic p3,
    input  logic p2,
    input  logic p1,
    input  logic p0,
    output logic g3,
    output logic g2,
    output logic g1,
    output logic g0,
    output logic y1,
    output logic y0,
    output logic busy,
    output logic seg_a,
    output logic seg_b,
    output logic seg_c,
    output logic seg_d,
    output logic seg_e,
    output logic seg_f,
    output logic seg_g
);

    // The counter reads 0 in the first GRANT cycle, so "held N cycles"
    // corresponds to the counter showing N-1.
    localparam logic [3:0] C_MIN_LIM = 4'(MIN_HOLD - 1);
    localparam logic [3:0] C_MAX_LIM = 4'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [3:0] g_q,     g_d;
    logic [1:0] y_q,     y_d;
    logic       busy_q,  busy_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [1:0] ptr_q,   ptr_d;

    mode_e      w_mode;
    logic [3:0] w_req;
    logic [1:0] w_fix_idx;
    logic [1:0] w_rr_idx;
    logic       w_rr_found;
    logic [1:0] w_cand;
    logic       w_owner_req;
    logic       w_other_req;
    logic       w_release;
    logic [3:0] w_cnt_inc;

    assign w_mode      = mode_e'({e1, e0});
    assign w_req       = {p3, p2, p1, p0};
    assign w_owner_req = |(w_req & g_q);
    assign w_other_req = |(w_req & ~g_q);
    assign w_cnt_inc   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    // Fixed priority: p3 wins over everything below it.
    always_comb begin
        w_fix_idx = 2'd0;
        if      (w_req[3]) w_fix_idx = 2'd3;
        else if (w_req[2]) w_fix_idx = 2'd2;
        else if (w_req[1]) w_fix_idx = 2'd1;
    end

    // Round robin: scan ptr+1, ptr+2, ptr+3, ptr (2-bit wrap), first hit wins.
    always_comb begin
        w_rr_idx   = 2'd0;
        w_rr_found = 1'b0;
        w_cand     = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_cand = ptr_q + 2'(i);
            if (!w_rr_found && w_req[w_cand]) begin
                w_rr_idx   = w_cand;
                w_rr_found = 1'b1;
            end
        end
    end

    // Lock mode is excluded here; it freezes the grant instead.
    assign w_release = ((cnt_q >= C_MIN_LIM) && !w_owner_req) ||
                       ((w_mode == MODE_RR) && (cnt_q >= C_MAX_LIM) && w_other_req);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        y_d     = y_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;

        if (w_mode == MODE_OFF) begin
            state_d = ST_IDLE;
            g_d     = 4'b0000;
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((w_mode == MODE_FIXED || w_mode == MODE_RR) && |w_req) begin
                        state_d = ST_GRANT;
                        busy_d  = 1'b1;
                        cnt_d   = 4'd0;
                        if (w_mode == MODE_RR) begin
                            y_d   = w_rr_idx;
                            g_d   = 4'b0001 << w_rr_idx;
                            ptr_d = w_rr_idx;
                        end else begin
                            y_d   = w_fix_idx;
                            g_d   = 4'b0001 << w_fix_idx;
                        end
                    end
                end
                default: begin // ST_GRANT
                    if (w_mode != MODE_LOCK && w_release) begin
                        state_d = ST_IDLE;
                        g_d     = 4'b0000;
                        busy_d  = 1'b0;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = w_cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            g_q     <= 4'b0000;
            y_q     <= 2'd0;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            ptr_q   <= 2'd3;   // first round-robin scan then begins at 0
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign {g3, g2, g1, g0} = g_q;
    assign {y1, y0}         = y_q;
    assign busy             = busy_q;

    decod_7seg u_decod_7seg (
        .idx   (y_q),
        .blank (~busy_q),
        .seg_a (seg_a),
        .seg_b (seg_b),
        .seg_c (seg_c),
        .seg_d (seg_d),
        .seg_e (seg_e),
        .seg_f (seg_f),
        .seg_g (seg_g)
    );

endmodule : arbitro_rr
`default_nettype wire

// File: tb/tb_arbitro_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbitro_rr
//  Description : Directed self-checking bench for arbitro_rr (default
//                parameters MIN_HOLD=4, MAX_HOLD=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr;

    logic clk = 1'b0;
    logic rst, e1, e0, p3, p2, p1, p0;
    logic g3, g2, g1, g0, y1, y0, busy;
    logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arbitro_rr #(.MIN_HOLD(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst), .e1(e1), .e0(e0),
        .p3(p3), .p2(p2), .p1(p1), .p0(p0),
        .g3(g3), .g2(g2), .g1(g1), .g0(g0),
        .y1(y1), .y0(y0), .busy(busy),
        .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
        .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g)
    );

    // Expected glyph {a..g} from busy and index
    function automatic logic [6:0] seg_model(input logic b, input logic [1:0] idx);
        if (!b) return 7'b0000001;
        case (idx)
            2'd0:    return 7'b1111110;
            2'd1:    return 7'b0110000;
            2'd2:    return 7'b1101101;
            default: return 7'b1111001;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] mode, input logic [3:0] req);
        {e1, e0}         = mode;
        {p3, p2, p1, p0} = req;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ey,
                       input logic eb);
        logic [13:0] obs;
        logic [13:0] expv;
        obs  = {g3, g2, g1, g0, y1, y0, busy,
                seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
        expv = {eg, ey, eb, seg_model(eb, ey)};
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed g/y/busy/seg=%b expected %b", tag, obs, expv);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        set_in(2'b00, 4'b0000);
        tick();
        tick();
        chk("reset", 4'b0000, 2'd0, 1'b0);

        // ---------------- fixed priority, all requesting ----------------
        rst = 1'b0;
        set_in(2'b00, 4'b1111);
        tick();
        chk("fix_p1111_grant", 4'b1000, 2'd3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fix_hold_p3", 4'b1000, 2'd3, 1'b1);
        end

        // owner drops, already past minimum hold -> one idle cycle
        set_in(2'b00, 4'b0000);
        tick();
        chk("fix_release", 4'b0000, 2'd3, 1'b0);

        // ---------------- p0 single-cycle pulse ----------------
        set_in(2'b00, 4'b0001);
        tick();
        chk("pulse_grant", 4'b0001, 2'd0, 1'b1);
        set_in(2'b00, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pulse_min_hold", 4'b0001, 2'd0, 1'b1);
        end
        tick();
        chk("pulse_release", 4'b0000, 2'd0, 1'b0);
        tick();
        chk("pulse_stay_idle", 4'b0000, 2'd0, 1'b0);

        // ---------------- round robin rotation ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(2'b01, 4'b1111);
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) begin
                chk("rr_grant", 4'b0001 << (k % 4), 2'(k % 4), 1'b1);
                tick();
            end
            chk("rr_gap", 4'b0000, 2'(k % 4), 1'b0);
            tick();
        end
        // grant to 1 is active now (counter 0); only p2 left requesting
        chk("rr_after_wrap", 4'b0010, 2'd1, 1'b1);
        set_in(2'b01, 4'b0100);
        tick();
        tick();
        tick();
        chk("rr_min_hold_1", 4'b0010, 2'd1, 1'b1);
        tick();
        chk("rr_release_1", 4'b0000, 2'd1, 1'b0);
        tick();
        chk("rr_grant_2", 4'b0100, 2'd2, 1'b1);

        // ---------------- lock mode holds requester 2 ----------------
        set_in(2'b10, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("lock_hold", 4'b0100, 2'd2, 1'b1);
        end
        set_in(2'b01, 4'b0000);
        tick();
        chk("unlock_release", 4'b0000, 2'd2, 1'b0);
        tick();
        chk("unlock_idle", 4'b0000, 2'd2, 1'b0);

        // lock mode in IDLE grants nothing
        set_in(2'b10, 4'b1111);
        tick();
        chk("lock_idle_nogrant", 4'b0000, 2'd2, 1'b0);

        // ---------------- disable mid-grant ----------------
        set_in(2'b01, 4'b1000);    // ptr=2 -> next scan hits 3
        tick();
        chk("rr_grant_3", 4'b1000, 2'd3, 1'b1);
        tick();
        set_in(2'b11, 4'b1000);
        tick();
        chk("off_drop", 4'b0000, 2'd3, 1'b0);
        tick();
        chk("off_stay", 4'b0000, 2'd3, 1'b0);

        // ---------------- fixed priority, mixed pattern ----------------
        set_in(2'b00, 4'b0110);
        tick();
        chk("fix_p0110", 4'b0100, 2'd2, 1'b1);

        // ---------------- reset during GRANT ----------------
        set_in(2'b00, 4'b0100);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_in_grant", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk("grant_after_rst", 4'b0100, 2'd2, 1'b1);

        // ---------------- RR: lone owner is never preempted ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(2'b01, 4'b0010);   // after reset scan starts at 0 -> finds 1
        tick();
        for (int i = 0; i < 12; i++) begin
            chk("rr_lone_owner", 4'b0010, 2'd1, 1'b1);
            tick();
        end
        set_in(2'b01, 4'b0000);
        tick();
        chk("rr_lone_release", 4'b0000, 2'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_arbitro_rr
`default_nettype wire
